pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter and branch-resolution stage of the single-cycle RV32I core. It sits directly downstream of the ALU and consumes the ALU's `zero`, `Con_BLT` and `Con_BGT` flags and its `ALUResult`. From these it resolves conditional branches, JAL and JALR, holds the architectural PC register, raises a misaligned-target trap, and supports fetch stalls.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TRAP_VEC`, default 32'h0000_0100: PC value loaded on a misaligned-target trap.

Ports:
- `clk` input, 1 bit: the single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `Stall` input, 1 bit: instruction memory not ready; freeze all state.
- `Branch` input, 1 bit: current instruction is a conditional branch.
- `Jal` input, 1 bit: current instruction is JAL.
- `Jalr` input, 1 bit: current instruction is JALR.
- `Funct3` input, 3 bits: branch condition code.
- `zero`, `Con_BLT`, `Con_BGT` inputs, 1 bit each: ALU compare flags from the SUB (signed) or unsigned-branch operation.
- `ImmExt` input, 32 bits: sign-extended B- or J-immediate.
- `ALUResult` input, 32 bits: rs1+imm computed by the ALU for JALR.
- `PC` output, 32 bits: current PC (registered).
- `PCPlus4` output, 32 bits: PC+4, the link value for rd.
- `PCTarget` output, 32 bits: PC+ImmExt.
- `Taken` output, 1 bit: combinational; next PC is non-sequential.
- `Trap` output, 1 bit: registered one-cycle pulse.
- `InstRet` output, 32 bits: present only with `PERFCNT_EN`.
- `TakenCnt` output, 32 bits: present only with `PERFCNT_EN`.

## Operation
- Condition evaluation by `Funct3`:
  - 000 BEQ: `zero`
  - 001 BNE: `!zero`
  - 100 BLT and 110 BLTU: `Con_BLT`
  - 101 BGE and 111 BGEU: `!Con_BLT`
  - 010 and 011: never taken
- Signed versus unsigned comparison is the decoder's ALU-op choice. This block uses the flags only.
- Next-PC select priority is fixed: `Jalr` > `Jal` > (`Branch` && cond) > sequential.
  - JALR target is {ALUResult[31:1], 1'b0}.
  - JAL and taken-branch target is `PCTarget`.
  - Sequential target is `PCPlus4`.
- `Taken` = `Jalr` | `Jal` | (`Branch` & cond).
- Misaligned target: when `Taken` is high and target[1] = 1, the PC loads `TRAP_VEC` instead of the target, and `Trap` is 1 in the following cycle.
- Address arithmetic is 32-bit modulo 2^32. For example, PC 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no flag.
- `Con_BGT` is accepted but unused. It is reserved for a future compare-branch extension.

## Timing
- All state updates on the rising edge of `clk`.
- Reset values: `PC` = `RESET_PC`, `Trap` = 0, counters = 0. `PCPlus4`, `PCTarget` and `Taken` follow combinationally from the reset PC.
- `reset` overrides `Stall`.
- Next-PC latency is one cycle: the PC updates on the edge that ends the cycle in which control was presented.
- `Stall` = 1 behaviour:
  - `PC`, counters and `Trap` hold their values.
  - `Trap` does not re-pulse.
  - `Taken` still reflects the inputs combinationally.
  - No trap is taken.
- Reset asserted mid-stall or in a trap cycle: `PC` = `RESET_PC` next edge and `Trap` clears.
- A trap cycle is not itself squashed. Instruction fetch proceeds from `TRAP_VEC`.

## Configuration
- `PERFCNT_EN` defined:
  - `InstRet` increments on every non-stalled, non-reset cycle.
  - `TakenCnt` increments on every non-stalled cycle with `Taken` = 1, including trapped transfers.
  - Both counters are 32-bit and wrap to 0.
- `PERFCNT_EN` undefined: both counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package `riscv_pkg` holds:
  - Funct3 branch codes: `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - Enum `npc_sel_t` with values {NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR, NPC_TRAP}.
- One combinational sub-module, `branch_cond`, maps `Funct3` and the flags to cond. It is reused by a future pipelined core.

## Test plan
- Reset: assert `reset` for 2 cycles with `RESET_PC` = 32'h0000_0000 -> `PC` = 0, `Trap` = 0. With no control inputs, `PC` reads 4 and 8 on the following two edges.
- BEQ taken and not taken: PC = 32'h10, ImmExt = 32'h20, Funct3 = 000.
  - `zero` = 1 -> `Taken` = 1, next PC = 32'h30.
  - `zero` = 0 -> next PC = 32'h14.
- BGEU and BLT: Funct3 = 111 with Con_BLT = 0 -> taken. Funct3 = 100 with Con_BLT = 0 -> not taken. Funct3 = 010 with any flags -> not taken.
- JALR with priority: Jalr = Jal = Branch = 1, ALUResult = 32'h0000_0105 -> next PC = 32'h104, `PCPlus4` = old PC + 4.
- Misaligned JAL: PC = 0, ImmExt = 32'h6 -> next PC = 32'h100, `Trap` = 1 for exactly one cycle.
- Stall: hold `Stall` = 1 for 3 cycles during a taken branch -> `PC` unchanged and `InstRet` unchanged (with `PERFCNT_EN`). After release, `PC` = target and `TakenCnt` += 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared branch funct3 codes and next-PC select encoding
package riscv_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [2:0] {NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR, NPC_TRAP} npc_sel_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: maps funct3 and ALU compare flags to the branch condition (Con_BGT reserved)
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       con_blt,
  input  logic       con_bgt,
  output logic       cond
);
  logic unused_bgt;
  assign unused_bgt = con_bgt;
  always_comb begin
    cond = (funct3 == F3_BEQ) ? zero :
           (funct3 == F3_BNE) ? !zero :
           (funct3 == F3_BLT || funct3 == F3_BLTU) ? con_blt :
           (funct3 == F3_BGE || funct3 == F3_BGEU) ? !con_blt : 1'b0;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, branch/JAL/JALR resolution, misaligned-target trap; PERFCNT_EN adds InstRet/TakenCnt
module pc_branch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jal,
  input  logic        Jalr,
  input  logic [2:0]  Funct3,
  input  logic        zero,
  input  logic        Con_BLT,
  input  logic        Con_BGT,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCTarget,
  output logic        Taken,
  output logic        Trap
`ifdef PERFCNT_EN
  ,
  output logic [31:0] InstRet,
  output logic [31:0] TakenCnt
`endif
);
  logic        cond;
  logic        unused_alu0;
  logic [31:0] pc_q, pc_d, target;
  logic        trap_q, trap_d;
  npc_sel_t    raw_sel, npc_sel;
  assign unused_alu0 = ALUResult[0];
  branch_cond u_cond (
    .funct3 (Funct3),
    .zero   (zero),
    .con_blt(Con_BLT),
    .con_bgt(Con_BGT),
    .cond   (cond)
  );
  always_comb begin
    PCPlus4  = pc_q + 32'd4;
    PCTarget = pc_q + ImmExt;
    raw_sel  = Jalr ? NPC_JALR : Jal ? NPC_JAL : (Branch && cond) ? NPC_BR : NPC_SEQ;
    target   = (raw_sel == NPC_JALR) ? {ALUResult[31:1], 1'b0} :
               (raw_sel == NPC_SEQ) ? PCPlus4 : PCTarget;
    Taken    = raw_sel != NPC_SEQ;
    npc_sel  = (Taken && target[1]) ? NPC_TRAP : raw_sel;
    pc_d     = Stall ? pc_q : (npc_sel == NPC_TRAP) ? TRAP_VEC : target;
    trap_d   = Stall ? trap_q : npc_sel == NPC_TRAP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      trap_q <= trap_d;
    end
  end
  assign PC   = pc_q;
  assign Trap = trap_q;
`ifdef PERFCNT_EN
  logic [31:0] inst_ret_q, inst_ret_d, taken_cnt_q, taken_cnt_d;
  always_comb begin
    inst_ret_d  = Stall ? inst_ret_q : inst_ret_q + 32'd1;
    taken_cnt_d = Stall ? taken_cnt_q : taken_cnt_q + {31'd0, Taken};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_ret_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      inst_ret_q  <= inst_ret_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end
  assign InstRet  = inst_ret_q;
  assign TakenCnt = taken_cnt_q;
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed plus random stimulus checked against a behavioural PC model
module tb_pc_branch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
  logic        clk = 1'b0;
  logic        reset, stall, branch, jal, jalr, zero, con_blt, con_bgt;
  logic [2:0]  funct3;
  logic [31:0] imm_ext, alu_result, pc, pc_plus4, pc_target;
  logic        taken, trap;
  logic [31:0] m_pc, m_ir, m_tc;
  logic        m_trap;
  int          checks = 0, errors = 0;
`ifdef PERFCNT_EN
  logic [31:0] inst_ret, taken_cnt;
`endif
  always #5 clk = ~clk;
  pc_branch_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk      (clk),
    .reset    (reset),
    .Stall    (stall),
    .Branch   (branch),
    .Jal      (jal),
    .Jalr     (jalr),
    .Funct3   (funct3),
    .zero     (zero),
    .Con_BLT  (con_blt),
    .Con_BGT  (con_bgt),
    .ImmExt   (imm_ext),
    .ALUResult(alu_result),
    .PC       (pc),
    .PCPlus4  (pc_plus4),
    .PCTarget (pc_target),
    .Taken    (taken),
    .Trap     (trap)
`ifdef PERFCNT_EN
    ,
    .InstRet  (inst_ret),
    .TakenCnt (taken_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic branch_ok(input logic [2:0] f3, input logic z, input logic lt);
    case (f3)
      3'd0:       return z;
      3'd1:       return !z;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction
  task automatic step(input logic rs, input logic st, input logic br, input logic jl, input logic jr,
                      input logic [2:0] f3, input logic z, input logic lt, input logic gt,
                      input logic [31:0] imm, input logic [31:0] alu);
    logic        t;
    logic [31:0] tgt;
    @(negedge clk);
    reset = rs; stall = st; branch = br; jal = jl; jalr = jr; funct3 = f3;
    zero = z; con_blt = lt; con_bgt = gt; imm_ext = imm; alu_result = alu;
    #1;
    t   = jr | jl | (br & branch_ok(f3, z, lt));
    tgt = jr ? (alu & ~32'd1) : t ? m_pc + imm : m_pc + 32'd4;
    chk("taken", {31'd0, taken}, {31'd0, t});
    chk("pcplus4", pc_plus4, m_pc + 32'd4);
    chk("pctarget", pc_target, m_pc + imm);
    @(posedge clk);
    if (rs) begin
      m_pc = RST_PC; m_trap = 1'b0; m_ir = 0; m_tc = 0;
    end else if (!st) begin
      m_trap = t && tgt[1];
      m_pc   = m_trap ? TVEC : tgt;
      m_ir   = m_ir + 1;
      m_tc   = m_tc + {31'd0, t};
    end
    #1;
    chk("pc", pc, m_pc);
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
`ifdef PERFCNT_EN
    chk("instret", inst_ret, m_ir);
    chk("takencnt", taken_cnt, m_tc);
`endif
  endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'd0, 32'd0); endtask
  initial begin
    m_pc = 32'hDEAD_BEEF; m_trap = 1'b0; m_ir = 0; m_tc = 0;
    reset = 1; stall = 0; branch = 0; jal = 0; jalr = 0; funct3 = 0;
    zero = 0; con_blt = 0; con_bgt = 0; imm_ext = 0; alu_result = 0;
    @(posedge clk);
    m_pc = RST_PC;
    step(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'd0, 32'd0);
    step(1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 32'd0, 32'd0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    idle(); chk("seq4", pc, 32'h4);
    idle(); chk("seq8", pc, 32'h8);
    idle(); idle();
    step(0, 0, 1, 0, 0, 3'd0, 1, 0, 0, 32'h20, 32'd0); chk("beq_taken", pc, 32'h30);
    step(0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 32'd0, 32'h10);
    step(0, 0, 1, 0, 0, 3'd0, 0, 0, 0, 32'h20, 32'd0); chk("beq_not", pc, 32'h14);
    step(0, 0, 1, 0, 0, 3'd7, 0, 0, 0, 32'h20, 32'd0); chk("bgeu_taken", pc, 32'h34);
    step(0, 0, 1, 0, 0, 3'd4, 0, 0, 1, 32'h20, 32'd0); chk("blt_not", pc, 32'h38);
    step(0, 0, 1, 0, 0, 3'd2, 1, 1, 1, 32'h20, 32'd0); chk("f3_010", pc, 32'h3C);
    step(0, 0, 1, 1, 1, 3'd0, 1, 0, 0, 32'h40, 32'h105); chk("jalr_prio", pc, 32'h104);
    step(0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h6, 32'd0);
    chk("mis_pc", pc, 32'h100);
    chk("mis_trap", {31'd0, trap}, 32'd1);
    idle(); chk("trap_pulse", {31'd0, trap}, 32'd0);
    repeat (3) step(0, 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h40, 32'd0);
    chk("stall_pc", pc, 32'h104);
    step(0, 0, 1, 0, 0, 3'd0, 1, 0, 0, 32'h40, 32'd0); chk("stall_rel", pc, 32'h144);
    step(0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 32'd0, 32'hFFFF_FFFC);
    idle(); chk("wrap", pc, 32'h0);
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 5) == 0), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 1) ? 32'($urandom) : {28'($urandom_range(0, 7) == 0 ? '1 : '0), 4'($urandom)},
           32'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
